// File: rtl/cp0_regfile.sv
// cp0_regfile: Coprocessor-0 register file fed by the WB-stage retire bus.
// Holds BadVAddr, Count, Compare, Status, Cause and EPC (sel 0 only).
// mfc0 data is a combinational read of the addressed register; EPC, EXL and
// the pending-interrupt flag are exported for fetch redirect and flush logic.
//
// Build option:
//   CP0_TIMER_INT_EN  defined   -> Count/Compare timer and TI are present.
//                     undefined -> no timer storage; addresses 9/11 read 0,
//                                  TI is 0 and COUNT_DIV_LOG2 has no effect.
//
// Command handshake: there is no back-pressure. A command on wb_to_cp0_bus
// takes effect only in a cycle where wb_valid is 1, and is consumed on that
// clock edge. Within one command, ex outranks eret, which outranks mtc0.

module cp0_regfile #(
   parameter int COUNT_DIV_LOG2 = 1
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         wb_valid,
   input  logic [109:0] wb_to_cp0_bus,
   input  logic [5:0]   ext_int,
   output logic [31:0]  cp0_rdata,
   output logic [31:0]  cp0_epc,
   output logic         cp0_exl,
   output logic         has_int
);

   // Register addresses (sel is always 0)
   localparam logic [4:0] ADDR_BADVADDR = 5'd8;
   localparam logic [4:0] ADDR_COUNT    = 5'd9;
   localparam logic [4:0] ADDR_COMPARE  = 5'd11;
   localparam logic [4:0] ADDR_STATUS   = 5'd12;
   localparam logic [4:0] ADDR_CAUSE    = 5'd13;
   localparam logic [4:0] ADDR_EPC      = 5'd14;

   // Exception codes that carry a faulting address
   localparam logic [4:0] EXC_ADEL = 5'd4;
   localparam logic [4:0] EXC_ADES = 5'd5;

   // ------------------------------------------------------------------
   // Bus fields
   // ------------------------------------------------------------------
   logic        w_ex;
   logic [4:0]  w_excode;
   logic [31:0] w_badvaddr;
   logic        w_bd;
   logic [31:0] w_pc;
   logic        w_mtc0_we;
   logic [4:0]  w_addr;
   logic [31:0] w_wdata;
   logic        w_eret;

   assign w_ex       = wb_to_cp0_bus[109];
   assign w_excode   = wb_to_cp0_bus[108:104];
   assign w_badvaddr = wb_to_cp0_bus[103:72];
   assign w_bd       = wb_to_cp0_bus[71];
   assign w_pc       = wb_to_cp0_bus[70:39];
   assign w_mtc0_we  = wb_to_cp0_bus[38];
   assign w_addr     = wb_to_cp0_bus[37:33];
   assign w_wdata    = wb_to_cp0_bus[32:1];
   assign w_eret     = wb_to_cp0_bus[0];

   // ------------------------------------------------------------------
   // Qualified commands: mutually exclusive by construction
   // ------------------------------------------------------------------
   logic w_ex_v;
   logic w_eret_v;
   logic w_mtc0_v;

   assign w_ex_v   = wb_valid & w_ex;
   assign w_eret_v = wb_valid & w_eret & ~w_ex;
   assign w_mtc0_v = wb_valid & w_mtc0_we & ~w_ex & ~w_eret;

   logic w_wr_status;
   logic w_wr_cause;
   logic w_wr_epc;

   assign w_wr_status = w_mtc0_v & (w_addr == ADDR_STATUS);
   assign w_wr_cause  = w_mtc0_v & (w_addr == ADDR_CAUSE);
   assign w_wr_epc    = w_mtc0_v & (w_addr == ADDR_EPC);

   // ------------------------------------------------------------------
   // Architectural state
   // ------------------------------------------------------------------
   logic [31:0] r_badvaddr;
   logic [31:0] r_epc;
   logic [7:0]  r_status_im;
   logic        r_status_exl;
   logic        r_status_ie;
   logic        r_cause_bd;
   logic [5:0]  r_cause_ip_hw;   // Cause[15:10]
   logic [1:0]  r_cause_ip_sw;   // Cause[9:8]
   logic [4:0]  r_cause_exccode;

   logic        w_ti;            // Cause.TI
   logic [31:0] w_count;
   logic [31:0] w_compare;

   // ------------------------------------------------------------------
   // Timer: Count, Compare, divider and TI
   // ------------------------------------------------------------------
`ifdef CP0_TIMER_INT_EN
   localparam logic [3:0] DIV_MASK = 4'((32'd1 << COUNT_DIV_LOG2) - 32'd1);

   logic [31:0] r_count;
   logic [31:0] r_compare;
   logic [3:0]  r_div;
   logic        r_ti;
   logic [3:0]  w_div_next;
   logic        w_count_tick;
   logic        w_wr_count;
   logic        w_wr_compare;

   assign w_wr_count   = w_mtc0_v & (w_addr == ADDR_COUNT);
   assign w_wr_compare = w_mtc0_v & (w_addr == ADDR_COMPARE);
   // Divider only uses its low COUNT_DIV_LOG2 bits; wrap to 0 is the tick.
   assign w_div_next   = (r_div + 4'd1) & DIV_MASK;
   assign w_count_tick = (w_div_next == 4'd0);

   // Count and divider: an mtc0 load beats the increment and restarts the phase.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_count <= 32'd0;
         r_div   <= 4'd0;
      end else if (w_wr_count) begin
         r_count <= w_wdata;
         r_div   <= 4'd0;
      end else begin
         r_div <= w_div_next;
         if (w_count_tick) begin
            r_count <= r_count + 32'd1;
         end
      end
   end

   // Compare register and sticky timer flag; a Compare write clears TI even
   // when the match condition holds in the same cycle.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_compare <= 32'd0;
         r_ti      <= 1'b0;
      end else if (w_wr_compare) begin
         r_compare <= w_wdata;
         r_ti      <= 1'b0;
      end else if (r_count == r_compare) begin
         r_ti <= 1'b1;
      end
   end

   assign w_count   = r_count;
   assign w_compare = r_compare;
   assign w_ti      = r_ti;
`else
   assign w_count   = 32'd0;
   assign w_compare = 32'd0;
   assign w_ti      = 1'b0;

   // The divider setting has no effect without the timer.
   if (COUNT_DIV_LOG2 < 0) begin : g_no_timer_div
   end
`endif

   // ------------------------------------------------------------------
   // Status
   // ------------------------------------------------------------------
   // EXL is set by any exception, cleared by eret; mtc0 writes IM, EXL, IE.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_status_im  <= 8'd0;
         r_status_exl <= 1'b0;
         r_status_ie  <= 1'b0;
      end else if (w_ex_v) begin
         r_status_exl <= 1'b1;
      end else if (w_eret_v) begin
         r_status_exl <= 1'b0;
      end else if (w_wr_status) begin
         r_status_im  <= w_wdata[15:8];
         r_status_exl <= w_wdata[1];
         r_status_ie  <= w_wdata[0];
      end
   end

   // ------------------------------------------------------------------
   // Cause
   // ------------------------------------------------------------------
   // Hardware IP lines are resampled every cycle regardless of wb_valid.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_cause_ip_hw <= 6'd0;
      end else begin
         r_cause_ip_hw <= {ext_int[5] | w_ti, ext_int[4:0]};
      end
   end

   // BD and ExcCode from exceptions (BD frozen while nested); software IP by mtc0.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_cause_bd      <= 1'b0;
         r_cause_ip_sw   <= 2'd0;
         r_cause_exccode <= 5'd0;
      end else if (w_ex_v) begin
         r_cause_exccode <= w_excode;
         if (!r_status_exl) begin
            r_cause_bd <= w_bd;
         end
      end else if (w_wr_cause) begin
         r_cause_ip_sw <= w_wdata[9:8];
      end
   end

   // ------------------------------------------------------------------
   // EPC and BadVAddr
   // ------------------------------------------------------------------
   // EPC captures the restart PC (branch address for delay-slot faults)
   // only on a non-nested exception; otherwise it is a plain mtc0 target.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_epc <= 32'd0;
      end else if (w_ex_v) begin
         if (!r_status_exl) begin
            r_epc <= w_bd ? (w_pc - 32'd4) : w_pc;
         end
      end else if (w_wr_epc) begin
         r_epc <= w_wdata;
      end
   end

   // BadVAddr is read-only to software and loads only on address errors.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_badvaddr <= 32'd0;
      end else if (w_ex_v && ((w_excode == EXC_ADEL) || (w_excode == EXC_ADES))) begin
         r_badvaddr <= w_badvaddr;
      end
   end

   // ------------------------------------------------------------------
   // Read view and outputs
   // ------------------------------------------------------------------
   logic [31:0] w_status;
   logic [31:0] w_cause;

   assign w_status = {9'd0, 1'b1, 6'd0, r_status_im, 6'd0, r_status_exl, r_status_ie};
   assign w_cause  = {r_cause_bd, w_ti, 14'd0, r_cause_ip_hw, r_cause_ip_sw,
                      1'b0, r_cause_exccode, 2'd0};

   // mfc0 read mux on current state; a same-cycle mtc0 is not forwarded.
   always_comb begin
      cp0_rdata = 32'd0;
      case (w_addr)
         ADDR_BADVADDR: cp0_rdata = r_badvaddr;
         ADDR_COUNT:    cp0_rdata = w_count;
         ADDR_COMPARE:  cp0_rdata = w_compare;
         ADDR_STATUS:   cp0_rdata = w_status;
         ADDR_CAUSE:    cp0_rdata = w_cause;
         ADDR_EPC:      cp0_rdata = r_epc;
         default:       cp0_rdata = 32'd0;
      endcase
   end

   assign cp0_epc = r_epc;
   assign cp0_exl = r_status_exl;
   assign has_int = (|({r_cause_ip_hw, r_cause_ip_sw} & r_status_im))
                    & r_status_ie & ~r_status_exl;

endmodule

// File: tb/tb_cp0_regfile.sv
// tb_cp0_regfile: directed checks of cp0_regfile with hand-computed values.
// Timer checks compile only when CP0_TIMER_INT_EN is defined; otherwise the
// bench checks that Count/Compare are absent.

module tb_cp0_regfile;

   // ------------------------------------------------------------------
   // Clock / reset / DUT
   // ------------------------------------------------------------------
   logic         clk = 1'b0;
   logic         reset;
   logic         wb_valid;
   logic [109:0] wb_to_cp0_bus;
   logic [5:0]   ext_int;
   logic [31:0]  cp0_rdata;
   logic [31:0]  cp0_epc;
   logic         cp0_exl;
   logic         has_int;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   cp0_regfile #(.COUNT_DIV_LOG2(1)) dut (
      .clk           (clk),
      .reset         (reset),
      .wb_valid      (wb_valid),
      .wb_to_cp0_bus (wb_to_cp0_bus),
      .ext_int       (ext_int),
      .cp0_rdata     (cp0_rdata),
      .cp0_epc       (cp0_epc),
      .cp0_exl       (cp0_exl),
      .has_int       (has_int)
   );

   // ------------------------------------------------------------------
   // Checker
   // ------------------------------------------------------------------
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   // ------------------------------------------------------------------
   // Driver tasks (inputs change 1 time unit after the rising edge)
   // ------------------------------------------------------------------
   function automatic logic [109:0] pack(input logic ex, input logic [4:0] excode,
                                         input logic [31:0] badvaddr, input logic bd,
                                         input logic [31:0] pc, input logic mtc0_we,
                                         input logic [4:0] addr, input logic [31:0] wdata,
                                         input logic eret);
      return {ex, excode, badvaddr, bd, pc, mtc0_we, addr, wdata, eret};
   endfunction

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic idle(input logic [4:0] addr);
      wb_valid      = 1'b0;
      wb_to_cp0_bus = pack(1'b0, 5'd0, 32'd0, 1'b0, 32'd0, 1'b0, addr, 32'd0, 1'b0);
   endtask

   task automatic cmd(input logic valid, input logic ex, input logic [4:0] excode,
                      input logic [31:0] badvaddr, input logic bd, input logic [31:0] pc,
                      input logic mtc0_we, input logic [4:0] addr, input logic [31:0] wdata,
                      input logic eret);
      wb_valid      = valid;
      wb_to_cp0_bus = pack(ex, excode, badvaddr, bd, pc, mtc0_we, addr, wdata, eret);
      tick(1);
      idle(5'd0);
   endtask

   task automatic mtc0(input logic [4:0] addr, input logic [31:0] wdata);
      cmd(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 32'd0, 1'b1, addr, wdata, 1'b0);
   endtask

   task automatic exc(input logic [4:0] excode, input logic [31:0] badvaddr,
                      input logic bd, input logic [31:0] pc);
      cmd(1'b1, 1'b1, excode, badvaddr, bd, pc, 1'b0, 5'd0, 32'd0, 1'b0);
   endtask

   task automatic eret();
      cmd(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1);
   endtask

   task automatic rd(input logic [4:0] addr, input string tag, input logic [31:0] exp);
      idle(addr);
      #1;
      check(tag, cp0_rdata, exp);
   endtask

   // ------------------------------------------------------------------
   // Stimulus
   // ------------------------------------------------------------------
   initial begin
      reset   = 1'b1;
      ext_int = 6'd0;
      idle(5'd0);
      tick(3);

      // Reset state
      check("rst_epc", cp0_epc, 32'h0);
      check("rst_exl", cp0_exl, 32'h0);
      check("rst_has_int", has_int, 32'h0);
      rd(5'd12, "rst_status", 32'h0040_0000);
      rd(5'd13, "rst_cause", 32'h0);
      rd(5'd0, "rst_addr0", 32'h0);
      reset = 1'b0;

      // Park Compare far away so TI stays quiet during the non-timer checks
      mtc0(5'd11, 32'hFFFF_FFFF);

      // Writable-field masks
      mtc0(5'd13, 32'hFFFF_FFFF);
      rd(5'd13, "cause_wr_all", 32'h0000_0300);
      mtc0(5'd13, 32'h0);
      rd(5'd13, "cause_wr_zero", 32'h0);
      mtc0(5'd12, 32'hFFFF_FFFF);
      rd(5'd12, "status_wr_all", 32'h0040_FF03);
      check("status_exl_out", cp0_exl, 32'h1);
      mtc0(5'd12, 32'h0);
      rd(5'd12, "status_wr_zero", 32'h0040_0000);
      check("status_exl_clr", cp0_exl, 32'h0);
      mtc0(5'd16, 32'h1234_5678);
      rd(5'd16, "unmapped_read", 32'h0);
      rd(5'd12, "status_after_unmapped", 32'h0040_0000);

      // Exception 1: AdEL, not in delay slot, EXL=0
      exc(5'd4, 32'h0000_0003, 1'b0, 32'hBFC0_0100);
      check("ex1_epc", cp0_epc, 32'hBFC0_0100);
      check("ex1_exl", cp0_exl, 32'h1);
      rd(5'd8, "ex1_badvaddr", 32'h0000_0003);
      rd(5'd13, "ex1_cause", 32'h0000_0010);
      rd(5'd14, "ex1_epc_read", 32'hBFC0_0100);
      rd(5'd12, "ex1_status", 32'h0040_0002);

      // Exception 2: nested (EXL=1), bd=1 -> EPC/BD frozen, ExcCode updated
      exc(5'd8, 32'hDEAD_BEEF, 1'b1, 32'h8000_0008);
      check("ex2_epc_keep", cp0_epc, 32'hBFC0_0100);
      rd(5'd13, "ex2_cause", 32'h0000_0020);
      rd(5'd8, "ex2_badvaddr_keep", 32'h0000_0003);

      eret();
      check("eret_exl", cp0_exl, 32'h0);
      check("eret_epc_keep", cp0_epc, 32'hBFC0_0100);
      rd(5'd12, "eret_status", 32'h0040_0000);

      // Exception 3: AdES in delay slot at pc=0 -> EPC wraps to 0xFFFF_FFFC
      exc(5'd5, 32'h1234_5678, 1'b1, 32'h0000_0000);
      check("ex3_epc_wrap", cp0_epc, 32'hFFFF_FFFC);
      rd(5'd13, "ex3_cause", 32'h8000_0014);
      rd(5'd8, "ex3_badvaddr", 32'h1234_5678);
      eret();

      // ex + eret + mtc0 together: only the exception applies
      cmd(1'b1, 1'b1, 5'd12, 32'h0000_0044, 1'b0, 32'h0000_1000, 1'b1, 5'd12, 32'hFFFF_FFFF, 1'b1);
      check("prio_epc", cp0_epc, 32'h0000_1000);
      check("prio_exl", cp0_exl, 32'h1);
      rd(5'd12, "prio_status", 32'h0040_0002);
      rd(5'd13, "prio_cause", 32'h0000_0030);
      rd(5'd8, "prio_badvaddr_keep", 32'h1234_5678);
      eret();

      // Same command with wb_valid=0: nothing changes
      cmd(1'b0, 1'b1, 5'd12, 32'h0000_0044, 1'b0, 32'h0000_2000, 1'b1, 5'd12, 32'hFFFF_FFFF, 1'b1);
      check("novalid_exl", cp0_exl, 32'h0);
      check("novalid_epc", cp0_epc, 32'h0000_1000);
      rd(5'd12, "novalid_status", 32'h0040_0000);
      rd(5'd13, "novalid_cause", 32'h0000_0030);

      // eret + mtc0: the mtc0 is dropped
      cmd(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 32'd0, 1'b1, 5'd14, 32'hAAAA_AAAA, 1'b1);
      check("eret_mtc0_epc", cp0_epc, 32'h0000_1000);
      mtc0(5'd14, 32'h8000_0180);
      check("mtc0_epc", cp0_epc, 32'h8000_0180);

      // External interrupt on IP2
      mtc0(5'd12, 32'h0000_0401);
      ext_int = 6'b000001;
      tick(2);
      check("ext_has_int", has_int, 32'h1);
      rd(5'd13, "ext_cause", 32'h0000_0430);
      exc(5'd0, 32'h0, 1'b0, 32'h0000_2000);
      check("ext_exl_mask", has_int, 32'h0);
      eret();
      check("ext_after_eret", has_int, 32'h1);
      ext_int = 6'd0;
      tick(2);
      check("ext_released", has_int, 32'h0);

      // ext_int[5] feeds IP7
      mtc0(5'd12, 32'h0000_8001);
      ext_int = 6'b100000;
      tick(2);
      check("ext5_has_int", has_int, 32'h1);
      rd(5'd13, "ext5_cause", 32'h0000_8000);
      ext_int = 6'd0;
      tick(2);
      check("ext5_released", has_int, 32'h0);

`ifdef CP0_TIMER_INT_EN
      // Timer match: Compare=5, Count=0, divide-by-2
      mtc0(5'd11, 32'd5);
      mtc0(5'd9, 32'd0);
      tick(9);
      rd(5'd9, "count_e9", 32'd4);
      rd(5'd13, "cause_pre_match", 32'h0);
      tick(1);
      rd(5'd9, "count_e10", 32'd5);
      tick(1);
      rd(5'd13, "cause_ti_set", 32'h4000_0000);
      tick(1);
      check("timer_has_int", has_int, 32'h1);
      rd(5'd13, "cause_ti_ip7", 32'h4000_8000);
      rd(5'd9, "count_e12", 32'd6);
      tick(3);
      rd(5'd13, "ti_sticky", 32'h4000_8000);
      mtc0(5'd11, 32'd200);
      rd(5'd13, "ti_cleared", 32'h0000_8000);
      tick(1);
      check("timer_int_gone", has_int, 32'h0);

      // Match and Compare write in the same cycle: the clear wins
      mtc0(5'd9, 32'd200);
      mtc0(5'd11, 32'hFFFF_FFFF);
      rd(5'd13, "clear_wins", 32'h0);
      rd(5'd11, "compare_read", 32'hFFFF_FFFF);

      // Count wraps from all-ones to zero
      mtc0(5'd9, 32'hFFFF_FFFF);
      rd(5'd9, "count_max", 32'hFFFF_FFFF);
      tick(2);
      rd(5'd9, "count_wrap", 32'h0);
`else
      // Timer absent: Count/Compare read 0 and ignore writes
      mtc0(5'd9, 32'h0000_1234);
      rd(5'd9, "count_absent", 32'h0);
      mtc0(5'd11, 32'd5);
      rd(5'd11, "compare_absent", 32'h0);
      tick(12);
      rd(5'd13, "no_ti", 32'h0);
`endif

      // Reset mid-operation overrides a concurrent mtc0
      mtc0(5'd12, 32'h0000_8003);
      reset = 1'b1;
      cmd(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 32'd0, 1'b1, 5'd12, 32'hFFFF_FFFF, 1'b0);
      check("midrst_exl", cp0_exl, 32'h0);
      check("midrst_epc", cp0_epc, 32'h0);
      check("midrst_has_int", has_int, 32'h0);
      rd(5'd12, "midrst_status", 32'h0040_0000);
      rd(5'd9, "midrst_count", 32'h0);
      reset = 1'b0;
      tick(1);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
